rlbp_seq_ctrl: RTL and testbench
================================

# rlbp_seq_ctrl

Job sequencer for the RLBP datapath in the MixPix user macro. It accepts three 4-bit pixel rows from a requester over a valid/ready handshake and loads them into the RLBP row registers through `d` and `ce_d1..3`. It then starts the RLBP FSM, captures the 8-bit code, and hands that code to the parallel-to-serial stage. It reports completion, timeout and a job count to the Wishbone/LA status logic.

## Interface
- `TIMEOUT`, default 255: maximum cycles allowed in WAIT_DONE or WAIT_SER before an error is declared.
- `SER_BITS`, default 8: serial shift cycles after a P2S load.
- `wb_clk_i`  in  1  single clock.
- `wb_rst_i`  in  1  reset, synchronous, active-high.
- `cfg_start`  in  1  single-cycle job start request.
- `cfg_abort`  in  1  abort the job in progress.
- `row_data`  in  4  pixel row nibble.
- `row_valid`  in  1  row_data valid.
- `row_ready`  out  1  controller accepts a row.
- `rlbp_d`  out  4  row value to the RLBP `d` input.
- `rlbp_ce_d1`, `rlbp_ce_d2`, `rlbp_ce_d3`  out  1 each  row register enables, one-hot pulses.
- `rlbp_start`  out  1  start pulse to the RLBP FSM (logic-analyzer start).
- `rlbp_done`  in  1  RLBP FSM finished.
- `rlbp_code`  in  8  RLBP result; valid while `rlbp_done`=1.
- `p2s_data`  out  8  parallel word to the P2S stage.
- `p2s_en`  out  1  P2S load pulse.
- `p2s_ready`  in  1  P2S conversion complete.
- `busy`  out  1  a job is in progress.
- `done_pulse`  out  1  one-cycle job-complete strobe (irq source).
- `err_timeout`  out  1  sticky timeout flag.
- `result`  out  8  last captured code.
- `job_count`  out  16  completed-job counter.

## Operation
- States: IDLE, LOAD_R1, LOAD_R2, LOAD_R3, START, WAIT_DONE, LOAD_P2S, WAIT_SER, DONE.
- IDLE:
  - `row_ready`=0.
  - `cfg_start`=1 and `cfg_abort`=0 → LOAD_R1; `err_timeout` is cleared.
  - `cfg_start` in any other state is ignored.
- LOAD_Rn (n=1..3):
  - `row_ready`=1.
  - A handshake (`row_valid` & `row_ready`) in cycle T gives `rlbp_d`=`row_data` from T+1, held until the next row handshake.
  - `rlbp_ce_dn`=1 for exactly cycle T+1.
  - Next state is LOAD_R(n+1), or START after row 3.
  - With no handshake the controller waits indefinitely.
- START: `rlbp_start`=1 for one cycle, clear the timeout counter, → WAIT_DONE.
- WAIT_DONE:
  - `rlbp_done`=1 → `result`<=`rlbp_code`, → LOAD_P2S.
  - Otherwise the counter increments each cycle.
  - Counter == TIMEOUT → set `err_timeout`, → IDLE without `done_pulse` and without counting the job.
  - `rlbp_done` in the same cycle as the timeout: done wins.
- LOAD_P2S: `p2s_data`=`result`, `p2s_en`=1 for one cycle, clear both counters, → WAIT_SER.
- WAIT_SER:
  - Count SER_BITS cycles, ignoring `p2s_ready`.
  - Then `p2s_ready`=1 → DONE.
  - The same TIMEOUT rule applies, counted from WAIT_SER entry.
- DONE:
  - `done_pulse`=1 for one cycle.
  - `job_count`+1, wrapping 16'hFFFF→0.
  - → IDLE.
- `cfg_abort`=1 in any non-IDLE state:
  - → IDLE next cycle, all strobes 0.
  - No `done_pulse`, no count, `err_timeout` unchanged.
  - Abort has priority over every other event.
- `busy`=1 in every state except IDLE.
- `p2s_data` and `rlbp_d` hold their values until they are next written.

## Timing
- All outputs are registered.
- Reset values: all outputs 0, state IDLE, counters 0.
- Reset mid-job returns to IDLE next cycle with no strobes.
- `cfg_start` at cycle 0 → LOAD_R1 and `row_ready`=1 at cycle 1.
- With rows presented back-to-back (row_valid held high):
  - Rows are accepted at cycles 1, 2, 3.
  - `rlbp_ce_d1`, `rlbp_ce_d2`, `rlbp_ce_d3` pulse at cycles 2, 3, 4.
  - `rlbp_start` pulses at cycle 5.
- `rlbp_done` sampled at cycle D → `p2s_en` at D+1 → earliest `done_pulse` at D+SER_BITS+3 when `p2s_ready` is already high.
- Timeout: with no `rlbp_done`, `err_timeout` rises TIMEOUT+1 cycles after `rlbp_start`, and `busy` falls on the same cycle.
- Strobes are never asserted for more than one consecutive cycle.

## Test plan
- Nominal job:
  - Stimulus: start, rows 4'hA, 4'h5, 4'hF back-to-back; `rlbp_done` with code 8'h3C at 6 cycles after `rlbp_start`; `p2s_ready` held 1.
  - Required: ce pulses one-hot in order with `rlbp_d` values A, 5, F; `p2s_data`=8'h3C with one `p2s_en`; one `done_pulse`; `job_count`=1; `result`=8'h3C.
- Row back-pressure:
  - Stimulus: `row_valid` gaps of 3 cycles between rows.
  - Required: `row_ready` stays high, each ce pulses exactly once, and no `rlbp_start` until row 3 is accepted.
- Timeout, TIMEOUT=15:
  - Stimulus: `rlbp_done` never asserted.
  - Required: `err_timeout`=1 at 16 cycles after `rlbp_start`, `busy`=0, `job_count` unchanged, no `p2s_en`.
  - Then: a new `cfg_start` clears `err_timeout`.
- Abort and simultaneous events:
  - `cfg_abort` in WAIT_SER → IDLE next cycle, no `done_pulse`.
  - `rlbp_done` on the timeout cycle → job completes and `err_timeout` stays 0.
  - `cfg_start`+`cfg_abort` together in IDLE → stays IDLE.
- Wrap and reset:
  - Preload `job_count` to 16'hFFFF through 65535 jobs or a force, then run one job → 16'h0000.
  - Assert `wb_rst_i` during WAIT_DONE → all outputs 0 next cycle, and a later start works normally.

Source files
------------

// File: rtl/rlbp_seq_ctrl.sv
// Job sequencer for the RLBP datapath: loads three pixel rows, starts the RLBP FSM, captures
// its code, hands it to the P2S stage and keeps completion/timeout/job-count status.
module rlbp_seq_ctrl #(
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned SER_BITS = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cfg_start,
  input  logic        cfg_abort,
  input  logic [3:0]  row_data,
  input  logic        row_valid,
  output logic        row_ready,
  output logic [3:0]  rlbp_d,
  output logic        rlbp_ce_d1,
  output logic        rlbp_ce_d2,
  output logic        rlbp_ce_d3,
  output logic        rlbp_start,
  input  logic        rlbp_done,
  input  logic [7:0]  rlbp_code,
  output logic [7:0]  p2s_data,
  output logic        p2s_en,
  input  logic        p2s_ready,
  output logic        busy,
  output logic        done_pulse,
  output logic        err_timeout,
  output logic [7:0]  result,
  output logic [15:0] job_count
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned SW = $clog2(SER_BITS + 1);
  localparam logic [TW-1:0] TmoMax = TW'(TIMEOUT);
  localparam logic [SW-1:0] SerMax = SW'(SER_BITS);

  typedef enum logic [3:0] {
    StIdle,
    StLoadR1,
    StLoadR2,
    StLoadR3,
    StStart,
    StWaitDone,
    StLoadP2s,
    StWaitSer,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [SW-1:0]   ser_q, ser_d;
  logic            row_ready_q, row_ready_d;
  logic [3:0]      rlbp_d_q, rlbp_d_d;
  logic            ce1_q, ce1_d;
  logic            ce2_q, ce2_d;
  logic            ce3_q, ce3_d;
  logic            start_q, start_d;
  logic [7:0]      p2s_data_q, p2s_data_d;
  logic            p2s_en_q, p2s_en_d;
  logic            busy_q, busy_d;
  logic            done_pulse_q, done_pulse_d;
  logic            err_q, err_d;
  logic [7:0]      result_q, result_d;
  logic [15:0]     job_count_q, job_count_d;
  logic            row_hs;

  // Strobes are decoded from this cycle's transition so they appear together with the new state.
  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    ser_d        = ser_q;
    rlbp_d_d     = rlbp_d_q;
    ce1_d        = 1'b0;
    ce2_d        = 1'b0;
    ce3_d        = 1'b0;
    start_d      = 1'b0;
    p2s_data_d   = p2s_data_q;
    p2s_en_d     = 1'b0;
    done_pulse_d = 1'b0;
    err_d        = err_q;
    result_d     = result_q;
    job_count_d  = job_count_q;
    row_hs       = row_valid & row_ready_q;

    if (cfg_abort && (state_q != StIdle)) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cfg_start && !cfg_abort) begin
            state_d = StLoadR1;
            err_d   = 1'b0;
          end
        end
        StLoadR1: begin
          if (row_hs) begin
            rlbp_d_d = row_data;
            ce1_d    = 1'b1;
            state_d  = StLoadR2;
          end
        end
        StLoadR2: begin
          if (row_hs) begin
            rlbp_d_d = row_data;
            ce2_d    = 1'b1;
            state_d  = StLoadR3;
          end
        end
        StLoadR3: begin
          if (row_hs) begin
            rlbp_d_d = row_data;
            ce3_d    = 1'b1;
            state_d  = StStart;
          end
        end
        StStart: begin
          start_d = 1'b1;
          tmo_d   = '0;
          state_d = StWaitDone;
        end
        StWaitDone: begin
          // A done arriving on the timeout cycle still completes the job.
          if (rlbp_done) begin
            result_d   = rlbp_code;
            p2s_data_d = rlbp_code;
            p2s_en_d   = 1'b1;
            state_d    = StLoadP2s;
          end else if (tmo_q == TmoMax) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        StLoadP2s: begin
          tmo_d   = '0;
          ser_d   = '0;
          state_d = StWaitSer;
        end
        StWaitSer: begin
          if ((ser_q == SerMax) && p2s_ready) begin
            done_pulse_d = 1'b1;
            job_count_d  = job_count_q + 16'd1;
            state_d      = StDone;
          end else if (tmo_q == TmoMax) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            tmo_d = tmo_q + 1'b1;
            if (ser_q != SerMax) begin
              ser_d = ser_q + 1'b1;
            end
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    busy_d      = (state_d != StIdle);
    row_ready_d = (state_d == StLoadR1) || (state_d == StLoadR2) || (state_d == StLoadR3);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= StIdle;
      tmo_q        <= '0;
      ser_q        <= '0;
      row_ready_q  <= 1'b0;
      rlbp_d_q     <= '0;
      ce1_q        <= 1'b0;
      ce2_q        <= 1'b0;
      ce3_q        <= 1'b0;
      start_q      <= 1'b0;
      p2s_data_q   <= '0;
      p2s_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_pulse_q <= 1'b0;
      err_q        <= 1'b0;
      result_q     <= '0;
      job_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      ser_q        <= ser_d;
      row_ready_q  <= row_ready_d;
      rlbp_d_q     <= rlbp_d_d;
      ce1_q        <= ce1_d;
      ce2_q        <= ce2_d;
      ce3_q        <= ce3_d;
      start_q      <= start_d;
      p2s_data_q   <= p2s_data_d;
      p2s_en_q     <= p2s_en_d;
      busy_q       <= busy_d;
      done_pulse_q <= done_pulse_d;
      err_q        <= err_d;
      result_q     <= result_d;
      job_count_q  <= job_count_d;
    end
  end

  assign row_ready   = row_ready_q;
  assign rlbp_d      = rlbp_d_q;
  assign rlbp_ce_d1  = ce1_q;
  assign rlbp_ce_d2  = ce2_q;
  assign rlbp_ce_d3  = ce3_q;
  assign rlbp_start  = start_q;
  assign p2s_data    = p2s_data_q;
  assign p2s_en      = p2s_en_q;
  assign busy        = busy_q;
  assign done_pulse  = done_pulse_q;
  assign err_timeout = err_q;
  assign result      = result_q;
  assign job_count   = job_count_q;

  a_ce_onehot: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
    $onehot0({ce1_q, ce2_q, ce3_q}));
  a_start_single: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
    start_q |=> !start_q);
  a_p2s_single: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
    p2s_en_q |=> !p2s_en_q);
  a_done_single: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
    done_pulse_q |=> !done_pulse_q);

endmodule

// File: tb/tb_rlbp_seq_ctrl.sv
// Bench for rlbp_seq_ctrl: directed scenarios with literal checks plus random traffic, all
// compared every cycle against a timestamp-based job model.
module tb_rlbp_seq_ctrl;

  localparam int TMO = 15;
  localparam int SER = 8;

  localparam int SgIdle = 0;
  localparam int SgRows = 1;
  localparam int SgKick = 2;
  localparam int SgWait = 3;
  localparam int SgLoad = 4;
  localparam int SgSer  = 5;
  localparam int SgFin  = 6;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic        cfg_start;
  logic        cfg_abort;
  logic [3:0]  row_data;
  logic        row_valid;
  logic        row_ready;
  logic [3:0]  rlbp_d;
  logic        rlbp_ce_d1;
  logic        rlbp_ce_d2;
  logic        rlbp_ce_d3;
  logic        rlbp_start;
  logic        rlbp_done;
  logic [7:0]  rlbp_code;
  logic [7:0]  p2s_data;
  logic        p2s_en;
  logic        p2s_ready;
  logic        busy;
  logic        done_pulse;
  logic        err_timeout;
  logic [7:0]  result;
  logic [15:0] job_count;

  always #5 clk = ~clk;

  rlbp_seq_ctrl #(
    .TIMEOUT (TMO),
    .SER_BITS(SER)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (wb_rst_i),
    .cfg_start  (cfg_start),
    .cfg_abort  (cfg_abort),
    .row_data   (row_data),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .rlbp_d     (rlbp_d),
    .rlbp_ce_d1 (rlbp_ce_d1),
    .rlbp_ce_d2 (rlbp_ce_d2),
    .rlbp_ce_d3 (rlbp_ce_d3),
    .rlbp_start (rlbp_start),
    .rlbp_done  (rlbp_done),
    .rlbp_code  (rlbp_code),
    .p2s_data   (p2s_data),
    .p2s_en     (p2s_en),
    .p2s_ready  (p2s_ready),
    .busy       (busy),
    .done_pulse (done_pulse),
    .err_timeout(err_timeout),
    .result     (result),
    .job_count  (job_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: expected outputs for the current cycle, derived from the job rules and timestamps.
  int          stage = SgIdle;
  int          rows = 0;
  int          t_mark = 0;
  int          mcyc = 0;
  logic        preload_on = 1'b0;
  logic        m_rdy = 1'b0;
  logic [3:0]  m_d = '0;
  logic [2:0]  m_ce = '0;
  logic        m_start = 1'b0;
  logic [7:0]  m_p2s_data = '0;
  logic        m_p2s_en = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_err = 1'b0;
  logic [7:0]  m_result = '0;
  logic [15:0] m_count = '0;

  task automatic model_step();
    logic [2:0] ce;
    logic st, en, dn;
    ce = '0;
    st = 1'b0;
    en = 1'b0;
    dn = 1'b0;
    if (wb_rst_i) begin
      stage      = SgIdle;
      m_d        = '0;
      m_p2s_data = '0;
      m_err      = 1'b0;
      m_result   = '0;
      m_count    = '0;
    end else if (cfg_abort && stage != SgIdle) begin
      stage = SgIdle;
    end else begin
      case (stage)
        SgIdle: if (cfg_start && !cfg_abort) begin
          stage = SgRows;
          rows  = 0;
          m_err = 1'b0;
        end
        SgRows: if (row_valid) begin
          m_d      = row_data;
          ce[rows] = 1'b1;
          rows++;
          if (rows == 3) stage = SgKick;
        end
        SgKick: begin
          st     = 1'b1;
          stage  = SgWait;
          t_mark = mcyc + 1;
        end
        SgWait: begin
          if (rlbp_done) begin
            m_result   = rlbp_code;
            m_p2s_data = rlbp_code;
            en         = 1'b1;
            stage      = SgLoad;
          end else if (mcyc - t_mark == TMO) begin
            m_err = 1'b1;
            stage = SgIdle;
          end
        end
        SgLoad: begin
          stage  = SgSer;
          t_mark = mcyc + 1;
        end
        SgSer: begin
          if (mcyc - t_mark >= SER && p2s_ready) begin
            dn      = 1'b1;
            m_count = m_count + 16'd1;
            stage   = SgFin;
          end else if (mcyc - t_mark == TMO) begin
            m_err = 1'b1;
            stage = SgIdle;
          end
        end
        default: stage = SgIdle;
      endcase
    end
    m_ce     = ce;
    m_start  = st;
    m_p2s_en = en;
    m_done   = dn;
    m_busy   = (stage != SgIdle);
    m_rdy    = (stage == SgRows);
  endtask

  task automatic compare_all();
    chk("row_ready", 32'(row_ready), 32'(m_rdy));
    chk("rlbp_d", 32'(rlbp_d), 32'(m_d));
    chk("ce_d1", 32'(rlbp_ce_d1), 32'(m_ce[0]));
    chk("ce_d2", 32'(rlbp_ce_d2), 32'(m_ce[1]));
    chk("ce_d3", 32'(rlbp_ce_d3), 32'(m_ce[2]));
    chk("rlbp_start", 32'(rlbp_start), 32'(m_start));
    chk("p2s_data", 32'(p2s_data), 32'(m_p2s_data));
    chk("p2s_en", 32'(p2s_en), 32'(m_p2s_en));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done_pulse", 32'(done_pulse), 32'(m_done));
    chk("err_timeout", 32'(err_timeout), 32'(m_err));
    chk("result", 32'(result), 32'(m_result));
    chk("job_count", 32'(job_count), 32'(m_count));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (preload_on) m_count = 16'hFFFF;
      compare_all();
      model_step();
      mcyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_rows(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    row_valid = 1'b1;
    row_data  = a;
    tick();
    row_data = b;
    tick();
    row_data = c;
    tick();
    row_valid = 1'b0;
  endtask

  task automatic wait_start(input string name, input int budget);
    int n = 0;
    while (!rlbp_start && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(rlbp_start), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  task automatic run_job(input logic [7:0] code, input int dly);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    load_rows(4'h3, 4'hC, 4'h6);
    wait_start("job_start", 8);
    repeat (dly) tick();
    rlbp_done = 1'b1;
    rlbp_code = code;
    tick();
    rlbp_done = 1'b0;
    wait_idle("job_idle", 40);
  endtask

  int n_ce1, n_ce2, n_ce3, n_st, gap_rdy, n_en, n_dp;
  int unsigned thr;

  task automatic tally();
    n_ce1 += int'(rlbp_ce_d1);
    n_ce2 += int'(rlbp_ce_d2);
    n_ce3 += int'(rlbp_ce_d3);
    n_st  += int'(rlbp_start);
  endtask

  initial begin
    wb_rst_i  = 1'b1;
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    row_data  = '0;
    row_valid = 1'b0;
    rlbp_done = 1'b0;
    rlbp_code = '0;
    p2s_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    wb_rst_i = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(job_count), 32'd0);

    // Nominal job: start at cycle 0, rows A/5/F back-to-back, done 6 cycles after start.
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("nom_ready_c1", 32'(row_ready), 32'd1);
    chk("nom_ready_c1_model", 32'(m_rdy), 32'd1);
    row_valid = 1'b1;
    row_data  = 4'hA;
    tick();
    chk("nom_ce1_c2", 32'({rlbp_ce_d3, rlbp_ce_d2, rlbp_ce_d1}), 32'h1);
    chk("nom_d_A", 32'(rlbp_d), 32'hA);
    row_data = 4'h5;
    tick();
    chk("nom_ce2_c3", 32'({rlbp_ce_d3, rlbp_ce_d2, rlbp_ce_d1}), 32'h2);
    chk("nom_d_5", 32'(rlbp_d), 32'h5);
    row_data = 4'hF;
    tick();
    chk("nom_ce3_c4", 32'({rlbp_ce_d3, rlbp_ce_d2, rlbp_ce_d1}), 32'h4);
    chk("nom_d_F", 32'(rlbp_d), 32'hF);
    chk("nom_d_F_model", 32'(m_d), 32'hF);
    row_valid = 1'b0;
    tick();
    chk("nom_start_c5", 32'(rlbp_start), 32'd1);
    chk("nom_start_c5_model", 32'(m_start), 32'd1);
    repeat (6) tick();
    rlbp_done = 1'b1;
    rlbp_code = 8'h3C;
    tick();
    rlbp_done = 1'b0;
    rlbp_code = 8'h00;
    chk("nom_p2s_en_c12", 32'(p2s_en), 32'd1);
    chk("nom_p2s_data", 32'(p2s_data), 32'h3C);
    repeat (9) tick();
    chk("nom_no_done_c21", 32'(done_pulse), 32'd0);
    tick();
    chk("nom_done_c22", 32'(done_pulse), 32'd1);
    chk("nom_done_c22_model", 32'(m_done), 32'd1);
    chk("nom_count", 32'(job_count), 32'd1);
    chk("nom_result", 32'(result), 32'h3C);
    wait_idle("nom_idle", 4);

    // Back-pressure: three idle cycles before each row.
    n_ce1 = 0; n_ce2 = 0; n_ce3 = 0; n_st = 0; gap_rdy = 0;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      row_valid = 1'b0;
      repeat (3) begin
        gap_rdy += int'(row_ready);
        tally();
        tick();
      end
      row_valid = 1'b1;
      row_data  = 4'(r + 7);
      tally();
      tick();
    end
    row_valid = 1'b0;
    tally();
    chk("bp_gap_ready", 32'(gap_rdy), 32'd9);
    chk("bp_ce1_once", 32'(n_ce1), 32'd1);
    chk("bp_ce2_once", 32'(n_ce2), 32'd1);
    chk("bp_ce3_once", 32'(n_ce3), 32'd1);
    chk("bp_no_early_start", 32'(n_st), 32'd0);
    chk("bp_last_row", 32'(rlbp_d), 32'h9);
    tick();
    chk("bp_start", 32'(rlbp_start), 32'd1);
    tick();
    rlbp_done = 1'b1;
    rlbp_code = 8'hE1;
    tick();
    rlbp_done = 1'b0;
    wait_idle("bp_idle", 40);
    chk("bp_count", 32'(job_count), 32'd2);

    // Timeout: no rlbp_done at all.
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    load_rows(4'h1, 4'h2, 4'h3);
    wait_start("to_start", 8);
    n_en = 0;
    repeat (TMO) begin
      n_en += int'(p2s_en);
      tick();
    end
    chk("to_err_early", 32'(err_timeout), 32'd0);
    chk("to_busy_early", 32'(busy), 32'd1);
    tick();
    chk("to_err", 32'(err_timeout), 32'd1);
    chk("to_err_model", 32'(m_err), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_count", 32'(job_count), 32'd2);
    chk("to_no_p2s", 32'(n_en + int'(p2s_en)), 32'd0);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("to_err_cleared", 32'(err_timeout), 32'd0);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    chk("abort_rows_busy", 32'(busy), 32'd0);

    // rlbp_done on the timeout cycle: done wins.
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    load_rows(4'h4, 4'h5, 4'h6);
    wait_start("tie_start", 8);
    repeat (TMO) tick();
    rlbp_done = 1'b1;
    rlbp_code = 8'h81;
    tick();
    rlbp_done = 1'b0;
    chk("tie_p2s_en", 32'(p2s_en), 32'd1);
    chk("tie_err", 32'(err_timeout), 32'd0);
    wait_idle("tie_idle", 40);
    chk("tie_count", 32'(job_count), 32'd3);
    chk("tie_result", 32'(result), 32'h81);
    chk("tie_err_end", 32'(err_timeout), 32'd0);

    // Abort during WAIT_SER.
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    load_rows(4'h7, 4'h8, 4'h9);
    wait_start("ab_start", 8);
    rlbp_done = 1'b1;
    rlbp_code = 8'h42;
    tick();
    rlbp_done = 1'b0;
    tick();
    tick();
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    chk("ab_busy", 32'(busy), 32'd0);
    n_dp = 0;
    repeat (12) begin
      n_dp += int'(done_pulse);
      tick();
    end
    chk("ab_no_done", 32'(n_dp), 32'd0);
    chk("ab_count", 32'(job_count), 32'd3);

    // Start and abort together in IDLE.
    cfg_start = 1'b1;
    cfg_abort = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    chk("sa_busy", 32'(busy), 32'd0);
    chk("sa_ready", 32'(row_ready), 32'd0);
    tick();
    chk("sa_busy2", 32'(busy), 32'd0);

    // Counter wrap via preload.
    force dut.job_count_q = 16'hFFFF;
    preload_on = 1'b1;
    tick();
    release dut.job_count_q;
    preload_on = 1'b0;
    tick();
    chk("wrap_preload", 32'(job_count), 32'hFFFF);
    run_job(8'h99, 3);
    chk("wrap_count", 32'(job_count), 32'h0000);

    // Reset during WAIT_DONE, then a normal job.
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    load_rows(4'hB, 4'hD, 4'hE);
    wait_start("rst_job_start", 8);
    repeat (3) tick();
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_result", 32'(result), 32'd0);
    chk("rst_mid_p2s", 32'(p2s_data), 32'd0);
    chk("rst_mid_d", 32'(rlbp_d), 32'd0);
    chk("rst_mid_count", 32'(job_count), 32'd0);
    run_job(8'h5A, 2);
    chk("rst_after_count", 32'(job_count), 32'd1);
    chk("rst_after_result", 32'(result), 32'h5A);

    // Random traffic.
    thr = 10;
    for (int i = 0; i < 20000; i++) begin
      if (i % 500 == 0) thr = $urandom_range(0, 10);
      wb_rst_i  = ($urandom_range(0, 999) < 3);
      cfg_start = ($urandom_range(0, 9) == 0);
      cfg_abort = ($urandom_range(0, 99) < 2);
      row_valid = ($urandom_range(0, 9) < 6);
      row_data  = 4'($urandom);
      rlbp_done = ($urandom_range(0, 99) < 8);
      rlbp_code = 8'($urandom);
      p2s_ready = ($urandom_range(0, 9) < thr);
      tick();
    end
    wb_rst_i  = 1'b0;
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    row_valid = 1'b0;
    rlbp_done = 1'b0;
    p2s_ready = 1'b1;
    repeat (40) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
